// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: state encoding, redirect kinds, reset PC.
// Optional alignment checking is enabled with the PC_ALIGN_CHECK_EN macro (see pc_sequencer.sv).
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_PEND = 2'd3
    } state_t;

    localparam logic [1:0] KIND_BRANCH = 2'b00;
    localparam logic [1:0] KIND_JUMP   = 2'b01;
    localparam logic [1:0] KIND_JREG   = 2'b10;
    localparam logic [1:0] KIND_RSVD   = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target: branch adds base and offset, every other kind uses the
// immediate as an absolute address. Addition wraps modulo 2^W.
module pc_target_calc
    import pc_sequencer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   i_kind,
    input  logic [W-1:0] i_base,
    input  logic [W-1:0] i_imm,
    output logic [W-1:0] o_target
);

    always_comb begin
        o_target = i_imm;
        case (i_kind)
            KIND_BRANCH:                    o_target = i_base + i_imm;
            KIND_JUMP, KIND_JREG, KIND_RSVD: o_target = i_imm;
            default:                        o_target = i_imm;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with stall hold and a one-entry redirect buffer for redirects that
// arrive under stall. Define PC_ALIGN_CHECK_EN to add the sticky align_err output.
//
//  state | meaning
//  BOOT  | first cycle after reset, pc = RESET_PC, redirects refused
//  RUN   | normal fetch, pc advances by 4 or takes a redirect
//  HOLD  | stalled with no buffered redirect, pc frozen
//  PEND  | stalled with a buffered redirect waiting for stall to drop
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int           W        = 32,
    parameter logic [W-1:0] RESET_PC = W'(DEFAULT_RESET_PC)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         stall,
    input  logic         redir_valid,
    input  logic [1:0]   redir_kind,
    input  logic [W-1:0] redir_base,
    input  logic [W-1:0] redir_imm,
    output logic         redir_ready,
`ifdef PC_ALIGN_CHECK_EN
    output logic         align_err,
`endif
    output logic [W-1:0] pc,
    output logic [W-1:0] pc_plus4,
    output logic         pend
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_pc;
    logic [W-1:0] r_buf;
    logic [W-1:0] w_pc_nxt;
    logic [W-1:0] w_buf_nxt;
    logic [W-1:0] w_target;
    logic [W-1:0] w_target_ld;
    logic         w_accept;

    pc_target_calc #(.W(W)) u_target (
        .i_kind   (redir_kind),
        .i_base   (redir_base),
        .i_imm    (redir_imm),
        .o_target (w_target)
    );

`ifdef PC_ALIGN_CHECK_EN
    logic r_align_err;

    assign w_target_ld = {w_target[W-1:2], 2'b00};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_align_err <= 1'b0;
        else if (w_accept && (w_target[1:0] != 2'b00))
            r_align_err <= 1'b1;
    end

    assign align_err = r_align_err;
`else
    assign w_target_ld = w_target;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_buf   <= w_buf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN, ST_HOLD: begin
                if (stall && redir_valid) w_state_nxt = ST_PEND;
                else if (stall)           w_state_nxt = ST_HOLD;
                else                      w_state_nxt = ST_RUN;
            end
            ST_PEND: if (!stall) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // HOLD releasing into a redirect or +4 behaves exactly like RUN, so they share a branch.
    always_comb begin
        w_accept  = 1'b0;
        w_pc_nxt  = r_pc;
        w_buf_nxt = r_buf;
        case (r_state)
            ST_RUN, ST_HOLD: begin
                w_accept = redir_valid;
                if (stall) begin
                    if (redir_valid) w_buf_nxt = w_target_ld;
                end else if (redir_valid) begin
                    w_pc_nxt = w_target_ld;
                end else begin
                    w_pc_nxt = r_pc + W'(4);
                end
            end
            ST_PEND: begin
                if (!stall) begin
                    w_pc_nxt  = r_buf;
                    w_buf_nxt = '0;
                end
            end
            default: ;
        endcase
    end

    assign redir_ready = w_accept;
    assign pend        = (r_state == ST_PEND);
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + W'(4);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, fetch address loaded on reset.
REQ-002 Parameter W, default 32, address width; all address ports are W bits.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active low.
REQ-005 stall  in  1  hazard hold from decode; freezes fetch PC.
REQ-006 redir_valid  in  1  decode presents a control transfer this cycle.
REQ-007 redir_kind  in  2  00 branch-taken, 01 jump, 10 jump-register, 11 reserved (treated as jump-register).
REQ-008 redir_base  in  W  PC of the branch instruction (branch kind only).
REQ-009 redir_imm  in  W  branch byte offset, or absolute target for jump and jump-register.
REQ-010 redir_ready  out  1  redirect accepted this cycle (valid and ready on the same edge).
REQ-011 pc  out  W  current fetch address, registered.
REQ-012 pc_plus4  out  W  pc + 4, combinational from pc.
REQ-013 pend  out  1  a redirect is buffered awaiting release of stall.

Function
REQ-014 States: BOOT, RUN, HOLD, PEND; BOOT is entered on reset and lasts exactly one cycle, then RUN.
REQ-015 Target: branch = redir_base + redir_imm, others = redir_imm; addition is modulo 2^W, carry discarded.
REQ-016 BOOT: pc holds RESET_PC, redir_ready = 0, stall ignored.
REQ-017 RUN, no stall, no redirect: pc <= pc + 4 each edge; wrap from 32'hFFFF_FFFC to 0 is allowed.
REQ-018 RUN, redir_valid, no stall: redir_ready = 1, pc <= target on the next edge (one-cycle latency).
REQ-019 RUN, stall, no redirect: pc holds, next state HOLD.
REQ-020 RUN or HOLD, stall and redir_valid together: redir_ready = 1, target captured in one-entry buffer, pc holds, next state PEND.
REQ-021 HOLD: stall deasserted returns to RUN with same rules as RUN in that cycle (redirect or +4).
REQ-022 PEND: redir_ready = 0; while stall = 1, pc and buffer hold.
REQ-023 PEND, stall = 0: pc <= buffered target, buffer cleared, next state RUN; a new redir_valid that cycle is not accepted.
REQ-024 pend = 1 exactly in state PEND.
REQ-025 redir_ready is combinational from state, stall and redir_valid; never asserted without redir_valid.

Reset
REQ-026 reset_n low: immediately pc = RESET_PC, state = BOOT, buffer = 0, pend = 0, redir_ready = 0, align_err = 0.
REQ-027 Reset asserted mid-PEND discards the buffered target; no redirect is applied after release.
REQ-028 Release of reset_n is sampled synchronously; first increment occurs on the second edge after release.

Configuration
REQ-029 Macro PC_ALIGN_CHECK_EN: when defined, output align_err (1 bit) and target checking are compiled in.
REQ-030 With PC_ALIGN_CHECK_EN: an accepted target with bits [1:0] != 0 sets sticky align_err, the redirect is still accepted but pc <= {target[W-1:2], 2'b00}; align_err clears only on reset.
REQ-031 Without PC_ALIGN_CHECK_EN: no align_err port, target loaded unmodified.

Structure
REQ-032 Shared package holds state encoding (BOOT, RUN, HOLD, PEND), redir_kind codes and default RESET_PC constant.
REQ-033 One sub-module, pc_target_calc, computes the target combinationally from redir_kind, redir_base, redir_imm.

Verification
REQ-034 Reset release, no stall -> pc sequence 3000, 3000, 3004, 3008.
REQ-035 In RUN at pc 3010, branch base 300C imm 0000_0020 -> redir_ready = 1, next pc 302C.
REQ-036 stall and jump imm 0000_4000 together at pc 3020, stall held 3 cycles -> pend = 1, pc stays 3020, then pc 4000 on the edge stall drops, a second redirect that cycle gets redir_ready = 0.
REQ-037 pc FFFF_FFFC, no stall -> next pc 0000_0000.
REQ-038 reset_n pulsed low during PEND -> pc = 3000 asynchronously, pend = 0, buffered target never appears.
REQ-039 With PC_ALIGN_CHECK_EN, jump-register imm 0000_3006 -> pc 3004, align_err = 1 and stays until reset.
